// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Initiator side of the data memory port. Takes byte, halfword and word
// load/store requests from the CPU datapath and turns them into word-granular
// read/write strobes.
//   - Sub-word stores are done as read-modify-write.
//   - Loads are lane-extracted and sign- or zero-extended.
//   - Misaligned, reserved-size and out-of-range requests are rejected
//     without any memory strobe.
//
// Parameters
//   MEM_WORDS_LOG2 : log2 of memory depth in 32-bit words.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid/ready  : request handshake (ready only in IDLE)
//   req_we           : 1 store, 0 load
//   req_size         : 00 byte, 01 half, 10 word, 11 reserved
//   req_signed       : load extension mode
//   req_addr         : byte address
//   req_wdata        : right-aligned store data
//   resp_valid       : one-cycle completion pulse
//   resp_err         : request was rejected
//   resp_rdata       : load result (0 for stores and errors)
//   mem_rd, mem_wr   : registered read/write strobes
//   mem_addr         : registered word index
//   mem_wdata        : registered write data
//   mem_rdata        : read data, registered by memory on the mem_rd edge
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_WORDS_LOG2 = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [31:0] WORD_MASK = (32'd1 << MEM_WORDS_LOG2) - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD_CAP,
        S_MERGE,
        S_WRITE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    // Only the byte offset and the low half of the store data are needed
    // after accept: the word index lives in mem_addr, and word stores take
    // their data straight from the request.
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [15:0] wdata_lo_q, wdata_lo_d;

    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        req_bad;

    // Little-endian lane extraction with optional sign extension.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: load_extract = {{24{sgn & b[7]}}, b};
            SIZE_HALF: load_extract = {{16{sgn & h[15]}}, h};
            default:   load_extract = word;
        endcase
    endfunction

    // Replace the addressed lane(s) of the old word with new store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [15:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        r = word;
        if (size == SIZE_BYTE) begin
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (lane[1]) begin
            r[31:16] = wdata;
        end else begin
            r[15:0] = wdata;
        end
        store_merge = r;
    endfunction

    // Reserved size, misalignment, or any address bit above the memory range.
    always_comb begin
        req_bad = 1'b0;
        if (req_size == 2'b11) begin
            req_bad = 1'b1;
        end
        if (req_size == SIZE_HALF && req_addr[0] != 1'b0) begin
            req_bad = 1'b1;
        end
        if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) begin
            req_bad = 1'b1;
        end
        if ((req_addr >> (MEM_WORDS_LOG2 + 2)) != 32'd0) begin
            req_bad = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_lo_d    = addr_lo_q;
        wdata_lo_d   = wdata_lo_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        // Strobes and response are single-cycle pulses.
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    size_d     = req_size;
                    signed_d   = req_signed;
                    addr_lo_d  = req_addr[1:0];
                    wdata_lo_d = req_wdata[15:0];
                    mem_addr_d = (req_addr >> 2) & WORD_MASK;
                    if (req_bad) begin
                        state_d = S_ERR;
                    end else if (req_we && req_size == SIZE_WORD) begin
                        state_d     = S_WRITE;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d  = S_READ;
                        mem_rd_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                state_d = we_q ? S_MERGE : S_LOAD_CAP;
            end
            S_LOAD_CAP: begin
                resp_rdata_d = load_extract(mem_rdata, size_q, addr_lo_q, signed_q);
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_MERGE: begin
                mem_wdata_d = store_merge(mem_rdata, wdata_lo_q, size_q, addr_lo_q);
                mem_wr_d    = 1'b1;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_ERR: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Asynchronous reset clears every output immediately, so a write that is
    // in flight loses its strobe before the memory's falling-edge commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_lo_q    <= 2'b00;
            wdata_lo_q   <= 16'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_lo_q    <= addr_lo_d;
            wdata_lo_q   <= wdata_lo_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:63] = '{4: 32'h8899_AABB, default: 32'h0};

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    int          rv_cnt = 0;
    logic [31:0] last_wdata = 32'd0;

    load_store_unit #(.MEM_WORDS_LOG2(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read on the rising edge, commit on falling edge.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr[5:0]];
    end

    always @(negedge clk) begin
        if (mem_wr) mem[mem_addr[5:0]] <= mem_wdata;
    end

    // Strobe/response monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_wr) begin
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= mem_wdata;
        end
        if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
        if (resp_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_rd, input int exp_wr, input logic [31:0] exp_maddr);
        int n;
        int rd0;
        int wr0;
        logic [31:0] maddr;
        @(negedge clk);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rd0   = rd_cnt;
        wr0   = wr_cnt;
        maddr = mem_addr;
        n = 1;
        while (!resp_valid && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        check_eq({tag, "_rdata"}, resp_rdata, exp_rdata);
        check_eq({tag, "_nrd"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check_eq({tag, "_nwr"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        if (!exp_err) check_eq({tag, "_maddr"}, maddr, exp_maddr);
    endtask

    initial begin
        int n;
        int rv0;

        // Reset state
        #2;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rvalid", 32'(resp_valid), 32'd0);
        check_eq("rst_rerr", 32'(resp_err), 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_mrd", 32'(mem_rd), 32'd0);
        check_eq("rst_mwr", 32'(mem_wr), 32'd0);
        check_eq("rst_maddr", mem_addr, 32'd0);
        check_eq("rst_mwdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Loads from word 4 = 0x8899_AABB
        do_req("ld_sb13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 3, 1'b0, 32'hFFFF_FF88, 1, 0, 32'd4);
        do_req("ld_uh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 3, 1'b0, 32'h0000_8899, 1, 0, 32'd4);
        do_req("ld_sh10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 3, 1'b0, 32'hFFFF_AABB, 1, 0, 32'd4);
        do_req("ld_ub10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'h0000_00BB, 1, 0, 32'd4);
        do_req("ld_sb11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 3, 1'b0, 32'hFFFF_FFAA, 1, 0, 32'd4);

        // Word store then read back
        do_req("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 0, 1, 32'd8);
        check_eq("st_w20_wdata", last_wdata, 32'hDEAD_BEEF);
        check_eq("st_w20_mem", mem[8], 32'hDEAD_BEEF);
        do_req("ld_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1, 0, 32'd8);

        // Byte store read-modify-write
        do_req("st_b11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_005A, 4, 1'b0, 32'h0, 1, 1, 32'd4);
        check_eq("st_b11_wdata", last_wdata, 32'h8899_5ABB);
        check_eq("st_b11_mem", mem[4], 32'h8899_5ABB);

        // Rejected requests
        do_req("err_h21", 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 2, 1'b1, 32'h0, 0, 0, 32'd0);
        do_req("err_w22", 1'b1, 2'b10, 1'b0, 32'h22, 32'h1234_5678, 2, 1'b1, 32'h0, 0, 0, 32'd0);
        do_req("err_sz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 2, 1'b1, 32'h0, 0, 0, 32'd0);
        do_req("err_oor", 1'b0, 2'b10, 1'b0, 32'h0004_0000, 32'h0, 2, 1'b1, 32'h0, 0, 0, 32'd0);
        check_eq("err_mem8", mem[8], 32'hDEAD_BEEF);

        // Back-to-back: load word 0x10, then half store 0xCAFE at 0x22
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        while (!resp_valid && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("b2b_ld_lat", 32'(n), 32'd3);
        check_eq("b2b_ld_rdata", resp_rdata, 32'h8899_5ABB);
        check_eq("b2b_ready", 32'(req_ready), 32'd1);
        req_we = 1'b1; req_size = 2'b01; req_addr = 32'h22; req_wdata = 32'h0000_CAFE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("b2b_st_rvalid_drop", 32'(resp_valid), 32'd0);
        check_eq("b2b_st_busy", 32'(req_ready), 32'd0);
        check_eq("b2b_st_mrd", 32'(mem_rd), 32'd1);
        n = 1;
        while (!resp_valid && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("b2b_st_lat", 32'(n), 32'd4);
        check_eq("b2b_st_err", 32'(resp_err), 32'd0);
        check_eq("b2b_st_mem", mem[8], 32'hCAFE_BEEF);

        // Reset during WRITE of a half store
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'h0000_1234;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("rw_mwr_hi", 32'(mem_wr), 32'd1);
        check_eq("rw_mwdata", mem_wdata, 32'hCAFE_1234);
        rv0 = rv_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("rw_mwr_drop", 32'(mem_wr), 32'd0);
        check_eq("rw_rvalid", 32'(resp_valid), 32'd0);
        check_eq("rw_ready", 32'(req_ready), 32'd1);
        check_eq("rw_maddr", mem_addr, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rw_no_resp", 32'(rv_cnt - rv0), 32'd0);
        check_eq("rw_mem_kept", mem[8], 32'hCAFE_BEEF);
        do_req("rw_after", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'hCAFE_BEEF, 1, 0, 32'd8);

        check_eq("never_rd_wr", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the single-cycle-style data memory port. Accepts byte, halfword and word load/store requests from the CPU datapath and issues word-granular read and write strobes to the data memory. Sub-word stores are done as read-modify-write; loads are lane-extracted and sign- or zero-extended. Misaligned and out-of-range accesses are rejected without touching memory.

## Interface
Parameters:
- MEM_WORDS_LOG2, 16, log2 of memory depth in 32-bit words; byte addresses at or above 4·2^MEM_WORDS_LOG2 are out of range.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  high only in IDLE; request accepted on the rising edge where req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
- req_signed  input  1  loads only: 1 sign-extend, 0 zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle completion pulse; no backpressure.
- resp_err  output  1  valid with resp_valid: misaligned, reserved size, or out of range.
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
- mem_rd  output  1  read strobe to data memory.
- mem_wr  output  1  write strobe to data memory.
- mem_addr  output  32  word index = {zeros, req_addr[MEM_WORDS_LOG2+1:2]}.
- mem_wdata  output  32  write data.
- mem_rdata  input  32  memory read data, registered by memory on the rising edge where mem_rd = 1.

## Operation
- States: IDLE, READ, LOAD_CAP, MERGE, WRITE, ERR.
- On accept, latch we, size, signed, addr, wdata; check:
  - halfword with addr[0] ≠ 0, word with addr[1:0] ≠ 0, size 11, addr[31:MEM_WORDS_LOG2+2] ≠ 0 → ERR.
  - load → READ.
  - word store → WRITE, with mem_wdata = wdata.
  - byte/half store → READ.
- READ: mem_rd = 1 for one cycle. Next state is LOAD_CAP for a load, MERGE for a store.
- LOAD_CAP: mem_rdata valid. Extract the lane (little-endian):
  - byte lane = addr[1:0], bits [8·lane+7 : 8·lane].
  - half = addr[1] ? [31:16] : [15:0].
  - Extend per signed. Register into resp_rdata. → IDLE with resp_valid = 1.
- MERGE: replace the selected lane(s) of mem_rdata with the low bits of wdata. Register into mem_wdata. → WRITE.
- WRITE: mem_wr = 1 for exactly one cycle (memory commits on the falling edge). → IDLE with resp_valid = 1, resp_err = 0.
- ERR: no memory strobes. → IDLE with resp_valid = 1, resp_err = 1, resp_rdata = 0.
- mem_rd, mem_wr, mem_addr, mem_wdata are registered. mem_addr is held from accept until the return to IDLE.
- mem_rd and mem_wr are never high together. Neither is ever high in IDLE or ERR.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_err 0, resp_rdata 0, mem_rd 0, mem_wr 0, mem_addr 0, mem_wdata 0.
- Latency, counted in rising edges from the accept edge to the edge that raises resp_valid:
  - load: 3
  - word store: 2
  - sub-word store: 4
  - error: 2
- resp_valid is high in the first IDLE cycle. req_ready is also high that cycle, so back-to-back requests are allowed; a new accept in that cycle is legal.
- Reset asserted mid-transaction:
  - All outputs return to reset values immediately (asynchronous).
  - If reset asserts during WRITE before the falling edge, mem_wr drops and no write occurs.
  - No resp_valid is produced for the aborted request.
- Request inputs are ignored while req_ready = 0.

## Test plan
- Preload word 0x0000_0004 (byte addr 0x10) = 0x8899_AABB. Signed byte load at 0x13 → resp_rdata 0xFFFF_FF88 three edges after accept. Unsigned half load at 0x12 → 0x0000_8899.
- Word store 0xDEAD_BEEF at 0x20 → single mem_wr pulse, mem_addr 8, resp_valid two edges after accept. Subsequent word load returns 0xDEAD_BEEF.
- Byte store 0x5A at 0x11 over 0x8899_AABB → one mem_rd, then one mem_wr with mem_wdata 0x8899_5ABB, resp_valid four edges after accept.
- Error cases: half load at 0x21, word store at 0x22, size 11, and address 0x0004_0000 (default parameter) → resp_err 1, resp_rdata 0, mem_rd and mem_wr never asserted.
- Back-to-back: hold req_valid high across a load then a store → second accept in the resp_valid cycle, and both responses are correct.
- Drop rst_n during the WRITE cycle of a half store → mem_wr falls immediately, memory word unchanged, no resp_valid; the next request after rst_n rises completes normally.
